dht_multi_reader: RTL and testbench
===================================

Name: dht_multi_reader

Overview:
- Next-generation single-wire humidity/temperature sensor reader. Supersedes the fixed DHT11 controller.
- Supports DHT11 and DHT22/AM2302 framing, selected per transaction by a mode input.
- Adds bus timeouts, classified error codes, automatic retries and signed temperature output.
- Sits between the 1 MHz strobe generator / line edge detector and the binary-to-BCD display path.

Parameters:
- IDLE_US, 1_000_000: minimum guard interval between transactions, in strobes (1 us each); set to 1_000 for simulation.
- LW11_US, 18_000: master start-low time in DHT11 mode.
- LW22_US, 1_000: master start-low time in DHT22 mode.
- HG_US, 20: master release time before sampling the sensor response.
- RESP_TO_US, 200: maximum wait for each sensor response edge.
- BIT_TO_US, 120: maximum duration of any data-bit low or high phase.
- BIT1_TH_US, 50: a high phase of this length or longer decodes as 1.
- MAX_RETRY, 3: automatic retries after a failed transaction; 0 disables retries.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  reset.
- I_EN  in  1  request a poll; level-sensitive, sampled in READY.
- I_ST  in  1  1 us strobe; all FSM and counter updates are qualified by it.
- I_MODE  in  1  0 = DHT11, 1 = DHT22; latched on leaving READY.
- I_RIS  in  1  rising edge of the data line, aligned to I_ST.
- I_FALL  in  1  falling edge of the data line, aligned to I_ST.
- O_DHT  out  1  line drive; 0 = pull low, 1 = release.
- O_BUSY  out  1  transaction or guard interval in progress.
- O_ERR  out  1  last transaction failed after all retries.
- O_ERR_CODE  out  2  0 none, 1 no response, 2 bit timeout, 3 checksum.
- O_HUM  out  16  humidity: DHT11 {8'h00, int byte}; DHT22 raw value in 0.1 %RH.
- O_TEMP  out  16  signed two's-complement temperature: DHT11 integer deg C; DHT22 0.1 deg C.
- O_VALID  out  1  one-CLK pulse when O_HUM and O_TEMP update.
- O_RETRY  out  2  number of retries used by the last transaction (saturating).

Behaviour:
- One clock, CLK. Reset RST is asynchronous and active-high.
- Reset values:
  - O_DHT=1, O_BUSY=1, O_ERR=0, O_ERR_CODE=0, O_HUM=0, O_TEMP=0, O_VALID=0, O_RETRY=0.
  - State = GUARD; all counters 0.
- RST asserted mid-transaction releases the line (O_DHT=1) in the same cycle and restarts the guard interval.
- States:
  - GUARD: count IDLE_US strobes, then go to READY.
    - If a retry is pending, go straight to START instead.
    - Otherwise clear O_BUSY on entry to READY.
  - READY: on I_ST & I_EN, latch I_MODE, clear the retry count, set O_BUSY, then go to START.
  - START: O_DHT=0 for LW11_US or LW22_US strobes, selected by the latched mode. Then O_DHT=1 and go to REL.
  - REL: wait HG_US strobes, then go to RSP_LW.
  - RSP_LW: wait for I_RIS; on edge go to RSP_HG.
  - RSP_HG: wait for I_FALL; on edge clear the bit counter (0..39) and go to BIT_LW.
  - Response timeout: RSP_LW or RSP_HG exceeding RESP_TO_US takes the FAIL path with code 1.
  - BIT_LW: wait for I_RIS, then go to BIT_HG with the width counter cleared.
  - BIT_HG: count strobes; on I_FALL shift in (width >= BIT1_TH_US) MSB-first.
    - After bit 39, go to CHECK; otherwise go to BIT_LW.
  - Bit timeout: BIT_LW or BIT_HG exceeding BIT_TO_US takes the FAIL path with code 2.
  - CHECK (one strobe): compare (b4+b3+b2+b1) mod 256 with b0.
    - Match: update O_HUM/O_TEMP, O_ERR=0, O_ERR_CODE=0, O_RETRY=retry count, pulse O_VALID, go to GUARD.
    - Mismatch: FAIL path with code 3.
  - FAIL path:
    - If retry count < MAX_RETRY: increment it and go to GUARD with a retry pending. Outputs are not changed.
    - Otherwise: O_ERR=1, O_ERR_CODE=code, O_RETRY=retry count, O_HUM/O_TEMP keep their last good values, go to GUARD.
- DHT22 decode:
  - O_HUM={b4,b3}.
  - O_TEMP = b2[7] ? -{1'b0,b2[6:0],b1} : {1'b0,b2[6:0],b1}.
  - -0 is reported as 0.
- DHT11 decode: O_HUM={8'h00,b4}; O_TEMP={8'h00,b2}.
- Edge handling:
  - Edges arriving in states not waiting for them are ignored.
  - If I_RIS and I_FALL arrive on the same strobe, only the edge the current state waits for is acted on.
  - The timeout check takes priority over an edge on the same strobe where the counter reaches its limit.
- O_VALID goes high on the CLK cycle after the CHECK strobe, for exactly one CLK.
- O_DHT is 1 in every state except START.
- I_MODE changes during a transaction have no effect.

Test Plan:
- DHT11 mode, sensor model sends 0x37,0x00,0x18,0x00,0x4F -> O_DHT low for 18_000 strobes; then O_HUM=0x0037, O_TEMP=0x0018, one O_VALID pulse, O_ERR=0, O_RETRY=0.
- DHT22 mode, sensor model sends 0x02,0x8C,0x80,0x65,0x73 -> start-low of 1_000 strobes; O_HUM=0x028C (65.2 %RH), O_TEMP=0xFF9B (-10.1 C).
- No sensor response, MAX_RETRY=3 -> four start pulses separated by IDLE_US; then O_ERR=1, O_ERR_CODE=1, O_RETRY=3, O_HUM/O_TEMP unchanged.
- Checksum corrupted on the first attempt only -> retry succeeds; O_ERR=0, O_RETRY=1, correct values.
- Data line held high 150 us mid-frame -> bit timeout; after retries are exhausted, O_ERR_CODE=2.
- RST asserted during START -> O_DHT=1 in the same cycle, O_BUSY=1; no transaction starts before IDLE_US strobes have elapsed.

Source files
------------

// File: rtl/dht_multi_reader.sv
// Single-wire DHT11 / DHT22 humidity and temperature reader.
// Adds response/bit timeouts, error codes, retries and signed temperature.
`timescale 1ns/1ps

module dht_multi_reader #(
    parameter int unsigned IDLE_US    = 1_000_000,
    parameter int unsigned LW11_US    = 18_000,
    parameter int unsigned LW22_US    = 1_000,
    parameter int unsigned HG_US      = 20,
    parameter int unsigned RESP_TO_US = 200,
    parameter int unsigned BIT_TO_US  = 120,
    parameter int unsigned BIT1_TH_US = 50,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_EN,
    input  logic        I_ST,
    input  logic        I_MODE,
    input  logic        I_RIS,
    input  logic        I_FALL,
    output logic        O_DHT,
    output logic        O_BUSY,
    output logic        O_ERR,
    output logic [1:0]  O_ERR_CODE,
    output logic [15:0] O_HUM,
    output logic [15:0] O_TEMP,
    output logic        O_VALID,
    output logic [1:0]  O_RETRY
);

    // One shared strobe counter; wide enough for the 1 s guard interval.
    localparam int unsigned CW = 20;

    localparam logic [CW-1:0] C_IDLE = CW'(IDLE_US - 1);
    localparam logic [CW-1:0] C_LW11 = CW'(LW11_US - 1);
    localparam logic [CW-1:0] C_LW22 = CW'(LW22_US - 1);
    localparam logic [CW-1:0] C_HG   = CW'(HG_US - 1);
    localparam logic [CW-1:0] C_RTO  = CW'(RESP_TO_US - 1);
    localparam logic [CW-1:0] C_BTO  = CW'(BIT_TO_US - 1);
    localparam logic [CW-1:0] C_TH   = CW'(BIT1_TH_US);
    localparam logic [7:0]    C_MR   = 8'(MAX_RETRY);

    localparam logic [1:0] E_NORESP = 2'd1;
    localparam logic [1:0] E_BITTO  = 2'd2;
    localparam logic [1:0] E_CKSUM  = 2'd3;

    typedef enum logic [3:0] {
        S_GUARD,
        S_READY,
        S_START,
        S_REL,
        S_RSP_LW,
        S_RSP_HG,
        S_BIT_LW,
        S_BIT_HG,
        S_CHECK
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic [5:0]      r_bitcnt;
    logic [39:0]     r_data;
    logic            r_mode;
    logic [7:0]      r_retry;
    logic            r_pend;
    logic            r_dht;
    logic            r_busy;
    logic            r_err;
    logic [1:0]      r_code;
    logic [15:0]     r_hum;
    logic [15:0]     r_temp;
    logic            r_valid;
    logic [1:0]      r_retry_o;

    logic            w_fail;
    logic [1:0]      w_code;
    logic            w_ok;
    logic            w_shift;
    logic            w_bitv;
    logic            w_clrbit;
    logic            w_start;
    logic            w_retry_go;
    logic            w_to_ready;
    logic [CW-1:0]   w_lw;
    logic [7:0]      w_sum;
    logic [15:0]     w_mag;
    logic [15:0]     w_hum;
    logic [15:0]     w_temp;
    logic [1:0]      w_rsat;

    assign w_lw  = r_mode ? C_LW22 : C_LW11;
    assign w_sum = r_data[39:32] + r_data[31:24]
                 + r_data[23:16] + r_data[15:8];

    // DHT22 carries sign-magnitude temperature; negating a zero
    // magnitude yields zero, so -0 never appears on the output.
    assign w_mag  = {1'b0, r_data[22:8]};
    assign w_hum  = r_mode ? r_data[39:24] : {8'h00, r_data[39:32]};
    assign w_temp = r_mode ? (r_data[23] ? 16'(-w_mag) : w_mag)
                           : {8'h00, r_data[23:16]};

    assign w_rsat = (r_retry > 8'd3) ? 2'd3 : r_retry[1:0];

    // State register and strobe counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_GUARD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Next-state logic; timeouts are tested before edges so a limit
    // reached on the same strobe as an edge still fails.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_fail     = 1'b0;
        w_code     = 2'd0;
        w_ok       = 1'b0;
        w_shift    = 1'b0;
        w_bitv     = 1'b0;
        w_clrbit   = 1'b0;
        w_start    = 1'b0;
        w_retry_go = 1'b0;
        w_to_ready = 1'b0;
        if (I_ST) begin
            unique case (r_state)
                S_GUARD: begin
                    if (r_cnt == C_IDLE) begin
                        w_cnt_nx = '0;
                        if (r_pend) begin
                            w_state_nx = S_START;
                            w_retry_go = 1'b1;
                        end else begin
                            w_state_nx = S_READY;
                            w_to_ready = 1'b1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                S_READY: begin
                    if (I_EN) begin
                        w_state_nx = S_START;
                        w_start    = 1'b1;
                        w_cnt_nx   = '0;
                    end
                end
                S_START: begin
                    if (r_cnt == w_lw) begin
                        w_state_nx = S_REL;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                S_REL: begin
                    if (r_cnt == C_HG) begin
                        w_state_nx = S_RSP_LW;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                S_RSP_LW: begin
                    if (r_cnt == C_RTO) begin
                        w_fail = 1'b1;
                        w_code = E_NORESP;
                    end else if (I_RIS) begin
                        w_state_nx = S_RSP_HG;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                S_RSP_HG: begin
                    if (r_cnt == C_RTO) begin
                        w_fail = 1'b1;
                        w_code = E_NORESP;
                    end else if (I_FALL) begin
                        w_state_nx = S_BIT_LW;
                        w_cnt_nx   = '0;
                        w_clrbit   = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                S_BIT_LW: begin
                    if (r_cnt == C_BTO) begin
                        w_fail = 1'b1;
                        w_code = E_BITTO;
                    end else if (I_RIS) begin
                        w_state_nx = S_BIT_HG;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                S_BIT_HG: begin
                    if (r_cnt == C_BTO) begin
                        w_fail = 1'b1;
                        w_code = E_BITTO;
                    end else if (I_FALL) begin
                        w_shift  = 1'b1;
                        w_bitv   = (r_cnt >= C_TH);
                        w_cnt_nx = '0;
                        if (r_bitcnt == 6'd39) begin
                            w_state_nx = S_CHECK;
                        end else begin
                            w_state_nx = S_BIT_LW;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    w_cnt_nx = '0;
                    if (w_sum == r_data[7:0]) begin
                        w_ok       = 1'b1;
                        w_state_nx = S_GUARD;
                    end else begin
                        w_fail = 1'b1;
                        w_code = E_CKSUM;
                    end
                end
                default: begin
                    w_state_nx = S_GUARD;
                    w_cnt_nx   = '0;
                end
            endcase
            if (w_fail) begin
                w_state_nx = S_GUARD;
                w_cnt_nx   = '0;
            end
        end
    end

    // Line drive follows the next state so release is immediate on exit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dht <= 1'b1;
        end else begin
            r_dht <= (w_state_nx != S_START);
        end
    end

    // Transaction bookkeeping: mode latch, retry count, busy flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mode  <= 1'b0;
            r_retry <= '0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            if (w_start) begin
                r_mode  <= I_MODE;
                r_retry <= '0;
                r_pend  <= 1'b0;
                r_busy  <= 1'b1;
            end
            if (w_retry_go) begin
                r_pend <= 1'b0;
            end
            if (w_to_ready) begin
                r_busy <= 1'b0;
            end
            if (w_fail && (r_retry < C_MR)) begin
                r_retry <= r_retry + 1'b1;
                r_pend  <= 1'b1;
            end
        end
    end

    // Bit shifter, MSB-first, 40 bits per frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bitcnt <= '0;
            r_data   <= '0;
        end else begin
            if (w_clrbit) begin
                r_bitcnt <= '0;
            end else if (w_shift) begin
                r_bitcnt <= r_bitcnt + 1'b1;
            end
            if (w_shift) begin
                r_data <= {r_data[38:0], w_bitv};
            end
        end
    end

    // Result registers; a failure keeps the last good readings.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err     <= 1'b0;
            r_code    <= 2'd0;
            r_hum     <= '0;
            r_temp    <= '0;
            r_valid   <= 1'b0;
            r_retry_o <= 2'd0;
        end else begin
            r_valid <= w_ok;
            if (w_ok) begin
                r_hum     <= w_hum;
                r_temp    <= w_temp;
                r_err     <= 1'b0;
                r_code    <= 2'd0;
                r_retry_o <= w_rsat;
            end else if (w_fail && !(r_retry < C_MR)) begin
                r_err     <= 1'b1;
                r_code    <= w_code;
                r_retry_o <= w_rsat;
            end
        end
    end

    assign O_DHT      = r_dht;
    assign O_BUSY     = r_busy;
    assign O_ERR      = r_err;
    assign O_ERR_CODE = r_code;
    assign O_HUM      = r_hum;
    assign O_TEMP     = r_temp;
    assign O_VALID    = r_valid;
    assign O_RETRY    = r_retry_o;

endmodule

// File: tb/tb_dht_multi_reader.sv
// Bench for dht_multi_reader: table of transactions driven against a
// sensor model, results queued at stimulus time and checked at completion.
`timescale 1ns/1ps

module tb_dht_multi_reader;

    localparam int IDLE = 1000;
    localparam int LW11 = 18000;
    localparam int LW22 = 1000;

    logic        CLK;
    logic        RST;
    logic        I_EN;
    logic        I_ST;
    logic        I_MODE;
    logic        I_RIS;
    logic        I_FALL;
    logic        O_DHT;
    logic        O_BUSY;
    logic        O_ERR;
    logic [1:0]  O_ERR_CODE;
    logic [15:0] O_HUM;
    logic [15:0] O_TEMP;
    logic        O_VALID;
    logic [1:0]  O_RETRY;

    dht_multi_reader #(.IDLE_US(IDLE)) dut (
        .CLK(CLK), .RST(RST), .I_EN(I_EN), .I_ST(I_ST),
        .I_MODE(I_MODE), .I_RIS(I_RIS), .I_FALL(I_FALL),
        .O_DHT(O_DHT), .O_BUSY(O_BUSY), .O_ERR(O_ERR),
        .O_ERR_CODE(O_ERR_CODE), .O_HUM(O_HUM), .O_TEMP(O_TEMP),
        .O_VALID(O_VALID), .O_RETRY(O_RETRY)
    );

    // kind: 0 good, 1 no response, 2 line stuck high, 3 bad cksum once
    typedef struct {
        bit          mode;
        logic [39:0] fr;
        int          kind;
        bit          flip;
        logic [15:0] hum;
        logic [15:0] temp;
        bit          err;
        logic [1:0]  code;
        logic [1:0]  retry;
    } vec_t;

    typedef struct {
        logic [15:0] hum;
        logic [15:0] temp;
        bit          err;
        logic [1:0]  code;
        logic [1:0]  retry;
        int          nv;
    } exp_t;

    exp_t q[$];
    vec_t vecs[7];
    int   passed = 0;
    int   total  = 0;
    int   vcnt   = 0;
    int   v0     = 0;
    int   st_div = 1;
    int   st_ph  = 0;

    initial begin
        CLK = 1'b0;
        forever #10 CLK = ~CLK;
    end

    initial begin
        I_ST = 1'b0;
        forever begin
            @(negedge CLK);
            I_ST  = (st_ph == 0);
            st_ph = (st_ph + 1 >= st_div) ? 0 : st_ph + 1;
        end
    end

    always @(negedge CLK) begin
        if (O_VALID === 1'b1) vcnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic st_tick();
        do @(posedge CLK); while (I_ST !== 1'b1);
        #1;
    endtask

    task automatic send_edge(input int k, input bit r);
        repeat (k - 1) st_tick();
        if (r) I_RIS = 1'b1;
        else I_FALL = 1'b1;
        st_tick();
        I_RIS  = 1'b0;
        I_FALL = 1'b0;
    endtask

    task automatic wait_low(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 4000) begin
            st_tick();
            n++;
            if (O_DHT === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic meas_low(output int n);
        n = 1;
        while (n < 20000) begin
            st_tick();
            if (O_DHT !== 1'b0) break;
            n++;
        end
    endtask

    task automatic play(input logic [39:0] fr, input int kind);
        send_edge(30, 1'b0);
        send_edge(80, 1'b1);
        send_edge(80, 1'b0);
        for (int i = 0; i < 40; i++) begin
            send_edge(40, 1'b1);
            if (kind == 2 && i == 4) begin
                repeat (150) st_tick();
                send_edge(1, 1'b0);
                return;
            end
            send_edge(fr[39-i] ? 70 : 26, 1'b0);
        end
        send_edge(40, 1'b1);
    endtask

    task automatic finish_txn();
        exp_t e;
        int   n;
        n = 0;
        while (O_BUSY !== 1'b0 && n < 4000) begin
            st_tick();
            n++;
        end
        chk("busy_drop", int'(O_BUSY === 1'b0), 1);
        if (q.size() == 0) begin
            total++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = q.pop_front();
            chk("hum", int'(O_HUM), int'(e.hum));
            chk("temp", int'(O_TEMP), int'(e.temp));
            chk("err", int'(O_ERR), int'(e.err));
            chk("err_code", int'(O_ERR_CODE), int'(e.code));
            chk("retry", int'(O_RETRY), int'(e.retry));
            chk("valid_cnt", vcnt - v0, e.nv);
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.hum   = v.hum;
        e.temp  = v.temp;
        e.err   = v.err;
        e.code  = v.code;
        e.retry = v.retry;
        e.nv    = v.err ? 0 : 1;
        q.push_back(e);
        v0 = vcnt;
    endtask

    initial begin
        int   n;
        int   att;
        bit   ok;
        vec_t v;

        vecs[0] = '{1'b0, 40'h37_00_18_00_4F, 0, 1'b0,
                    16'h0037, 16'h0018, 1'b0, 2'd0, 2'd0};
        vecs[1] = '{1'b1, 40'h02_8C_80_65_73, 0, 1'b1,
                    16'h028C, 16'hFF9B, 1'b0, 2'd0, 2'd0};
        vecs[2] = '{1'b1, 40'h00_00_00_00_00, 1, 1'b0,
                    16'h028C, 16'hFF9B, 1'b1, 2'd1, 2'd3};
        vecs[3] = '{1'b1, 40'h01_F4_00_FA_EF, 3, 1'b0,
                    16'h01F4, 16'h00FA, 1'b0, 2'd0, 2'd1};
        vecs[4] = '{1'b1, 40'h00_00_80_00_80, 0, 1'b0,
                    16'h0000, 16'h0000, 1'b0, 2'd0, 2'd0};
        vecs[5] = '{1'b1, 40'hFF_FF_7F_FF_7C, 0, 1'b0,
                    16'hFFFF, 16'h7FFF, 1'b0, 2'd0, 2'd0};
        vecs[6] = '{1'b1, 40'h01_F4_00_FA_EF, 2, 1'b0,
                    16'hFFFF, 16'h7FFF, 1'b1, 2'd2, 2'd3};

        RST    = 1'b1;
        I_EN   = 1'b0;
        I_MODE = 1'b0;
        I_RIS  = 1'b0;
        I_FALL = 1'b0;
        st_div = 2;
        repeat (3) @(negedge CLK);
        chk("rst_dht", int'(O_DHT), 1);
        chk("rst_busy", int'(O_BUSY), 1);
        chk("rst_err", int'(O_ERR), 0);
        chk("rst_code", int'(O_ERR_CODE), 0);
        chk("rst_hum", int'(O_HUM), 0);
        chk("rst_temp", int'(O_TEMP), 0);
        chk("rst_valid", int'(O_VALID), 0);
        chk("rst_retry", int'(O_RETRY), 0);

        RST = 1'b0;
        n = 0;
        while (O_BUSY !== 1'b0 && n < 3000) begin
            st_tick();
            n++;
        end
        chk("guard_len", n, IDLE);
        st_div = 1;

        for (int i = 0; i < 7; i++) begin
            v      = vecs[i];
            I_MODE = v.mode;
            I_EN   = 1'b1;
            push_exp(v);
            att = (v.kind == 0) ? 1 : ((v.kind == 3) ? 2 : 4);
            for (int a = 0; a < att; a++) begin
                wait_low(n, ok);
                chk("start_seen", int'(ok), 1);
                if (!ok) break;
                if (a == 0) begin
                    I_EN = 1'b0;
                    if (v.flip) I_MODE = ~v.mode;
                end
                if (v.kind == 1 && a > 0) chk("retry_gap", int'(n >= IDLE), 1);
                meas_low(n);
                chk("start_len", n, v.mode ? LW22 : LW11);
                if (v.kind == 0) play(v.fr, 0);
                else if (v.kind == 2) play(v.fr, 2);
                else if (v.kind == 3) play((a == 0) ? (v.fr ^ 40'h1) : v.fr, 0);
            end
            I_EN = 1'b0;
            finish_txn();
        end

        I_MODE = 1'b1;
        I_EN   = 1'b1;
        wait_low(n, ok);
        chk("rst_txn_start", int'(ok), 1);
        repeat (10) st_tick();
        RST = 1'b1;
        #1;
        chk("midrst_dht", int'(O_DHT), 1);
        chk("midrst_busy", int'(O_BUSY), 1);
        chk("midrst_err", int'(O_ERR), 0);
        chk("midrst_hum", int'(O_HUM), 0);
        @(negedge CLK);
        RST = 1'b0;
        wait_low(n, ok);
        chk("guard_after_rst", n, IDLE + 1);
        I_EN = 1'b0;
        v = '{1'b1, 40'h02_8C_80_65_73, 0, 1'b0,
              16'h028C, 16'hFF9B, 1'b0, 2'd0, 2'd0};
        push_exp(v);
        meas_low(n);
        chk("start_len_rst", n, LW22);
        play(v.fr, 0);
        finish_txn();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
